// File: rtl/teclado_pkg.sv
// -----------------------------------------------------------------------------
// teclado_pkg
// Shared definitions for the keypad entry path: key codes produced by
// Driver_teclado, the highest decimal digit code, and the entry FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package teclado_pkg;

   localparam logic [4:0] TECLA_BORRAR  = 5'd10;
   localparam logic [4:0] TECLA_LIMPIAR = 5'd14;
   localparam logic [4:0] TECLA_ENTER   = 5'd15;
   localparam logic [4:0] DIGITO_MAX    = 5'd9;

   typedef enum logic {
      EDICION = 1'b0,
      LISTO   = 1'b1
   } estado_t;

endpackage : teclado_pkg

// File: rtl/registro_entrada_if.sv
// -----------------------------------------------------------------------------
// registro_entrada_if
// Bundles the key-event inputs and the entry/commit outputs of registro_entrada.
//   digito        : key code from Driver_teclado (5 bits)
//   cambio_digito : new-key indication, may stay high several cycles
//   ack           : consumer accepts valor
//   entrada       : live edit buffer, BCD, LSD in [3:0]
//   n_dig         : digits currently in the buffer
//   valor         : committed value, BCD
//   valido        : valor is valid, held until acked
//   desborde      : 1-cycle pulse when a digit is rejected (buffer full)
// Modports: master (key source + consumer side), slave (registro_entrada).
// -----------------------------------------------------------------------------
interface registro_entrada_if #(
   parameter int N_DIG = 4
);
   localparam int W  = 4 * N_DIG;
   localparam int NW = $clog2(N_DIG + 1);

   logic [4:0]    digito;
   logic          cambio_digito;
   logic          ack;
   logic [W-1:0]  entrada;
   logic [NW-1:0] n_dig;
   logic [W-1:0]  valor;
   logic          valido;
   logic          desborde;

   modport master (
      output digito, cambio_digito, ack,
      input  entrada, n_dig, valor, valido, desborde
   );

   modport slave (
      input  digito, cambio_digito, ack,
      output entrada, n_dig, valor, valido, desborde
   );

endinterface : registro_entrada_if

// File: rtl/registro_entrada_detector_flanco.sv
// -----------------------------------------------------------------------------
// detector_flanco
// 1-bit rising-edge detector. flanco_o is high in the cycle where sig_i is high
// and its registered copy is still low, so a held level yields one event.
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   sig_i    : monitored level
//   flanco_o : rising-edge indication (combinational from sig_i)
// -----------------------------------------------------------------------------
module detector_flanco (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_i,
   output logic flanco_o
);

   logic sig_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   assign flanco_o = sig_i & ~sig_q;

endmodule : detector_flanco

// File: rtl/registro_entrada.sv
// -----------------------------------------------------------------------------
// registro_entrada
// Keypad entry register downstream of Driver_teclado. Assembles a multi-digit
// BCD number from key events with backspace (10), clear (14, '*') and
// enter (15, '#'), and hands the committed value to a consumer through a
// valido/ack handshake.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : registro_entrada_if.slave (digito, cambio_digito, ack in;
//             entrada, n_dig, valor, valido, desborde out)
// Parameters: N_DIG (1..8 digits), TIMEOUT_CICLOS (idle cycles before
// auto-clear).
// Optional feature: define ENTRADA_TIMEOUT_EN to clear a partial entry after
// TIMEOUT_CICLOS idle cycles; without it TIMEOUT_CICLOS is unused.
// -----------------------------------------------------------------------------
module registro_entrada
   import teclado_pkg::*;
#(
   parameter int N_DIG          = 4,
   parameter int TIMEOUT_CICLOS = 50_000_000
) (
   input logic               clk,
   input logic               reset_n,
   registro_entrada_if.slave bus
);

   localparam int            W     = 4 * N_DIG;
   localparam int            NW    = $clog2(N_DIG + 1);
   localparam logic [NW-1:0] N_MAX = NW'(N_DIG);

   logic          evento;
   logic          es_digito, es_borrar, es_limpiar, es_enter;
   logic          enter_ok;
   logic          timeout_hit;

   estado_t       estado_q, estado_d;
   logic [W-1:0]  entrada_q, entrada_d;
   logic [NW-1:0] n_dig_q, n_dig_d;
   logic [W-1:0]  valor_q, valor_d;
   logic          desborde_q, desborde_d;

   detector_flanco u_flanco (
      .clk      (clk),
      .rst_n    (reset_n),
      .sig_i    (bus.cambio_digito),
      .flanco_o (evento)
   );

   // Key decode; codes 11-13 and 16-31 fall through all four and are ignored.
   assign es_digito  = evento && (bus.digito <= DIGITO_MAX);
   assign es_borrar  = evento && (bus.digito == TECLA_BORRAR);
   assign es_limpiar = evento && (bus.digito == TECLA_LIMPIAR);
   assign es_enter   = evento && (bus.digito == TECLA_ENTER);

   // ENTER only commits from EDICION with a non-empty buffer; in LISTO the key
   // is dropped (also when ack arrives in the same cycle).
   assign enter_ok = es_enter && (estado_q == EDICION) && (n_dig_q != '0);

`ifdef ENTRADA_TIMEOUT_EN
   localparam int            CW      = $clog2(TIMEOUT_CICLOS + 1);
   localparam logic [CW-1:0] CNT_FIN = CW'(TIMEOUT_CICLOS - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Counts idle cycles while a partial entry exists; any event restarts it.
   always_comb begin
      cnt_d       = cnt_q;
      timeout_hit = 1'b0;
      if (evento || (n_dig_q == '0)) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_FIN) begin
         timeout_hit = 1'b1;
         cnt_d       = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // FSM: state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         estado_q <= EDICION;
      end else begin
         estado_q <= estado_d;
      end
   end

   // FSM: next state
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         EDICION: if (enter_ok) estado_d = LISTO;
         LISTO:   if (bus.ack)  estado_d = EDICION;
         default:               estado_d = EDICION;
      endcase
   end

   // FSM: outputs
   always_comb begin
      bus.valido = (estado_q == LISTO);
   end

   // Edit buffer and commit register. timeout_hit is never set in an event
   // cycle, so the chain stays mutually exclusive.
   always_comb begin
      entrada_d  = entrada_q;
      n_dig_d    = n_dig_q;
      valor_d    = valor_q;
      desborde_d = 1'b0;
      if (es_digito) begin
         if (n_dig_q < N_MAX) begin
            entrada_d      = entrada_q << 4;
            entrada_d[3:0] = bus.digito[3:0];
            n_dig_d        = n_dig_q + NW'(1);
         end else begin
            desborde_d = 1'b1;
         end
      end else if (es_borrar) begin
         if (n_dig_q != '0) begin
            // Logical shift brings zero into the MSD.
            entrada_d = entrada_q >> 4;
            n_dig_d   = n_dig_q - NW'(1);
         end
      end else if (es_limpiar || timeout_hit) begin
         entrada_d = '0;
         n_dig_d   = '0;
      end else if (enter_ok) begin
         valor_d   = entrada_q;
         entrada_d = '0;
         n_dig_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         entrada_q  <= '0;
         n_dig_q    <= '0;
         valor_q    <= '0;
         desborde_q <= 1'b0;
      end else begin
         entrada_q  <= entrada_d;
         n_dig_q    <= n_dig_d;
         valor_q    <= valor_d;
         desborde_q <= desborde_d;
      end
   end

   assign bus.entrada  = entrada_q;
   assign bus.n_dig    = n_dig_q;
   assign bus.valor    = valor_q;
   assign bus.desborde = desborde_q;

endmodule : registro_entrada

// File: tb/tb_registro_entrada.sv
// -----------------------------------------------------------------------------
// tb_registro_entrada
// Self-checking bench for registro_entrada (N_DIG=4, TIMEOUT_CICLOS=20).
// A behavioural model produces the expected outputs for every driven cycle and
// pushes them to a scoreboard queue; they are popped and compared one cycle
// later, after the DUT edge. Directed checks use literal values.
// Build with +define+ENTRADA_TIMEOUT_EN to exercise the auto-clear.
// -----------------------------------------------------------------------------
module tb_registro_entrada;

   localparam int N_DIG = 4;
   localparam int TO    = 20;

   typedef struct {
      logic [15:0] ent;
      logic [2:0]  n;
      logic [15:0] val;
      logic        vld;
      logic        desb;
   } exp_t;

   logic clk;
   logic reset_n;

   registro_entrada_if #(.N_DIG(N_DIG)) bus ();

   registro_entrada #(
      .N_DIG          (N_DIG),
      .TIMEOUT_CICLOS (TO)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   exp_t sb[$];

   // Model state
   logic [15:0] m_ent;
   int          m_n;
   logic [15:0] m_val;
   logic        m_vld;
   logic        m_prev;
   int          m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelo_reset();
      m_ent  = '0;
      m_n    = 0;
      m_val  = '0;
      m_vld  = 1'b0;
      m_prev = 1'b0;
      m_cnt  = 0;
   endtask

   // Behavioural model of one clock edge; pushes the expected post-edge outputs.
   task automatic modelo(input logic cd, input logic [4:0] dg, input logic ak);
      exp_t e;
      logic ev, vld_old, desb, to;
      ev      = cd && !m_prev;
      m_prev  = cd;
      vld_old = m_vld;
      desb    = 1'b0;
      to      = 1'b0;
`ifdef ENTRADA_TIMEOUT_EN
      if (ev || m_n == 0) m_cnt = 0;
      else if (m_cnt == TO - 1) begin to = 1'b1; m_cnt = 0; end
      else m_cnt++;
`endif
      if (vld_old && ak) m_vld = 1'b0;
      if (ev && dg <= 5'd9) begin
         if (m_n < N_DIG) begin
            m_ent = {m_ent[11:0], dg[3:0]};
            m_n++;
         end else begin
            desb = 1'b1;
         end
      end else if (ev && dg == 5'd10) begin
         if (m_n > 0) begin
            m_ent = {4'h0, m_ent[15:4]};
            m_n--;
         end
      end else if ((ev && dg == 5'd14) || to) begin
         m_ent = '0;
         m_n   = 0;
      end else if (ev && dg == 5'd15 && !vld_old && m_n > 0) begin
         m_val = m_ent;
         m_vld = 1'b1;
         m_ent = '0;
         m_n   = 0;
      end
      e.ent  = m_ent;
      e.n    = 3'(m_n);
      e.val  = m_val;
      e.vld  = m_vld;
      e.desb = desb;
      sb.push_back(e);
   endtask

   task automatic revisar();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk("entrada",  32'(bus.entrada),  32'(e.ent));
         chk("n_dig",    32'(bus.n_dig),    32'(e.n));
         chk("valor",    32'(bus.valor),    32'(e.val));
         chk("valido",   32'(bus.valido),   32'(e.vld));
         chk("desborde", 32'(bus.desborde), 32'(e.desb));
      end
   endtask

   task automatic ciclo(input logic cd, input logic [4:0] dg, input logic ak);
      @(negedge clk);
      bus.cambio_digito = cd;
      bus.digito        = dg;
      bus.ack           = ak;
      modelo(cd, dg, ak);
      @(posedge clk);
      #1;
      revisar();
   endtask

   task automatic tecla(input logic [4:0] k);
      ciclo(1'b1, k, 1'b0);
      ciclo(1'b0, k, 1'b0);
   endtask

   task automatic ocioso(input int n);
      for (int i = 0; i < n; i++) ciclo(1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n           = 1'b0;
      bus.cambio_digito = 1'b0;
      bus.digito        = 5'd0;
      bus.ack           = 1'b0;
      modelo_reset();
      #12;
      chk("rst_entrada",  32'(bus.entrada),  32'h0);
      chk("rst_n_dig",    32'(bus.n_dig),    32'h0);
      chk("rst_valor",    32'(bus.valor),    32'h0);
      chk("rst_valido",   32'(bus.valido),   32'h0);
      chk("rst_desborde", 32'(bus.desborde), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Three single-cycle key pulses
      tecla(5'd1); tecla(5'd2); tecla(5'd3);
      chk("t1_entrada", 32'(bus.entrada), 32'h0123);
      chk("t1_n_dig",   32'(bus.n_dig),   32'd3);

      // Full buffer, overflow pulse, then backspace
      tecla(5'd14);
      tecla(5'd1); tecla(5'd2); tecla(5'd3); tecla(5'd4);
      ciclo(1'b1, 5'd5, 1'b0);
      chk("t2_desborde_on", 32'(bus.desborde), 32'd1);
      chk("t2_entrada",     32'(bus.entrada),  32'h1234);
      ciclo(1'b0, 5'd5, 1'b0);
      chk("t2_desborde_off", 32'(bus.desborde), 32'd0);
      tecla(5'd10);
      chk("t2_borrar",   32'(bus.entrada), 32'h0123);
      chk("t2_n_borrar", 32'(bus.n_dig),   32'd3);

      // Commit, edit while LISTO, ENTER dropped, ack
      tecla(5'd14);
      tecla(5'd4); tecla(5'd2); tecla(5'd15);
      chk("t3_valor",   32'(bus.valor),   32'h0042);
      chk("t3_valido",  32'(bus.valido),  32'd1);
      chk("t3_entrada", 32'(bus.entrada), 32'h0);
      ocioso(10);
      tecla(5'd7); tecla(5'd15);
      chk("t3_valido_hold", 32'(bus.valido),  32'd1);
      chk("t3_valor_hold",  32'(bus.valor),   32'h0042);
      chk("t3_entrada_7",   32'(bus.entrada), 32'h0007);
      ciclo(1'b0, 5'd0, 1'b1);
      chk("t3_ack", 32'(bus.valido), 32'd0);
      chk("t3_valor_after_ack", 32'(bus.valor), 32'h0042);

      // Held cambio_digito gives a single event; ENTER on empty buffer ignored
      tecla(5'd14);
      for (int i = 0; i < 5; i++) ciclo(1'b1, 5'd3, 1'b0);
      ciclo(1'b0, 5'd3, 1'b0);
      chk("t4_held_entrada", 32'(bus.entrada), 32'h0003);
      chk("t4_held_n",       32'(bus.n_dig),   32'd1);
      tecla(5'd14);
      tecla(5'd15);
      chk("t4_enter_empty", 32'(bus.valido), 32'd0);

      // Ignored codes, ack in EDICION, ack together with ENTER in LISTO
      tecla(5'd12); tecla(5'd20); tecla(5'd31);
      ciclo(1'b0, 5'd0, 1'b1);
      tecla(5'd9); tecla(5'd15);
      tecla(5'd8);
      ciclo(1'b1, 5'd15, 1'b1);
      ciclo(1'b0, 5'd15, 1'b0);
      chk("t5_ack_enter_vld", 32'(bus.valido),  32'd0);
      chk("t5_ack_enter_ent", 32'(bus.entrada), 32'h0008);
      chk("t5_valor",         32'(bus.valor),   32'h0009);

      // Idle timeout (or indefinite hold without the feature)
      tecla(5'd14);
      tecla(5'd5);
`ifdef ENTRADA_TIMEOUT_EN
      ocioso(18);
      chk("t6_pre_timeout", 32'(bus.entrada), 32'h0005);
      ocioso(1);
      chk("t6_timeout_ent", 32'(bus.entrada), 32'h0);
      chk("t6_timeout_n",   32'(bus.n_dig),   32'd0);
`else
      ocioso(100);
      chk("t6_hold_ent", 32'(bus.entrada), 32'h0005);
      chk("t6_hold_n",   32'(bus.n_dig),   32'd1);
`endif

      // Asynchronous reset between edges
      tecla(5'd14);
      tecla(5'd1); tecla(5'd15);
      tecla(5'd6); tecla(5'd7);
      chk("t7_pre_n",   32'(bus.n_dig),  32'd2);
      chk("t7_pre_vld", 32'(bus.valido), 32'd1);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t7_ar_entrada",  32'(bus.entrada),  32'h0);
      chk("t7_ar_n_dig",    32'(bus.n_dig),    32'h0);
      chk("t7_ar_valor",    32'(bus.valor),    32'h0);
      chk("t7_ar_valido",   32'(bus.valido),   32'h0);
      chk("t7_ar_desborde", 32'(bus.desborde), 32'h0);
      modelo_reset();
      @(negedge clk);
      reset_n = 1'b1;
      tecla(5'd2);
      chk("t7_post_entrada", 32'(bus.entrada), 32'h0002);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_registro_entrada
